seven_seg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for a NUM_DIGITS common-segment 7-segment display.

---
 rtl/seven_seg_scan_ctrl_if.sv | 21 ++
 rtl/seven_seg_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_ctrl_if.sv
// seven_seg_scan_ctrl_if: load handshake, scan controls and display drive of the scan controller
interface seven_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    disp_en;
  logic                    blank_lz;
  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;
  logic [7:1]              seven;
  logic [NUM_DIGITS-1:0]   digit_an;
  logic                    frame_done;
  modport master (
    output disp_en, blank_lz, load_valid, load_data,
    input  load_ready, seven, digit_an, frame_done
  );
  modport slave (
    input  disp_en, blank_lz, load_valid, load_data,
    output load_ready, seven, digit_an, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: tear-free time-multiplexed BCD scan controller for a multi-digit 7-segment display
module seven_seg_bcd_dec (
  input  logic [3:0] bcd,
  output logic [7:1] seg
);
  // gfedcba patterns; codes above 9 (including the blanking code F) are dark
  always_comb begin
    case (bcd)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
  end
endmodule

module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  seven_seg_scan_ctrl_if.slave bus
);
  localparam int CW = DIGIT_CYCLES > 1 ? $clog2(DIGIT_CYCLES) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;
  typedef enum logic [1:0] {S_OFF, S_BLANK, S_SHOW} state_t;
  localparam state_t SLOT_START = BLANK_CYCLES > 0 ? S_BLANK : S_SHOW;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         disp_q, disp_d, pend_q, pend_d;
  logic                  pending_q, pending_d;
  logic                  blz_q, blz_d;
  logic [7:1]            seven_q, seven_d, seg;
  logic [NUM_DIGITS-1:0] an_q, an_d, lz;
  logic                  frame_done_q, frame_done_d;
  logic                  ready_q;
  logic                  xfer, frame_last;
  logic [3:0]            nib, code;

  seven_seg_bcd_dec u_dec (
    .bcd(code),
    .seg(seg)
  );

  // scan position: every slot restarts with the anti-ghost gap, disable forces OFF with counters at 0
  always_comb begin
    frame_last = state_q == S_SHOW && cnt_q == CW'(DIGIT_CYCLES - 1) && idx_q == IW'(NUM_DIGITS - 1);
    cnt_d = '0;
    idx_d = '0;
    state_d = S_OFF;
    if (bus.disp_en && state_q == S_OFF) begin
      state_d = SLOT_START;
    end else if (bus.disp_en && cnt_q == CW'(DIGIT_CYCLES - 1)) begin
      idx_d = idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + IW'(1);
      state_d = SLOT_START;
    end else if (bus.disp_en) begin
      cnt_d = cnt_q + CW'(1);
      idx_d = idx_q;
      state_d = int'(cnt_d) >= BLANK_CYCLES ? S_SHOW : S_BLANK;
    end
  end

  // loads go straight to the display while off; while scanning they wait for the frame boundary
  always_comb begin
    xfer = bus.load_valid && ready_q;
    disp_d = disp_q;
    pend_d = pend_q;
    pending_d = pending_q;
    if (pending_q && (state_q == S_OFF || frame_last)) begin
      disp_d = pend_q;
      pending_d = 1'b0;
    end else if (xfer && state_q == S_OFF) begin
      disp_d = bus.load_data;
    end else if (xfer) begin
      pend_d = bus.load_data;
      pending_d = 1'b1;
    end
  end

  // next-cycle display drive, so segments and enables register together on one edge
  always_comb begin
    lz = '0;
    for (int i = 0; i < NUM_DIGITS; i++) lz[i] = (disp_d >> (4 * i)) == '0;
    blz_d = state_d == S_SHOW && int'(cnt_d) == BLANK_CYCLES ? bus.blank_lz : blz_q;
    nib = disp_d[{idx_d, 2'b00} +: 4];
    code = idx_d != '0 && blz_d && lz[idx_d] ? 4'hF : nib;
    seven_d = state_d == S_SHOW ? seg : '0;
    an_d = state_d == S_SHOW ? NUM_DIGITS'(1) << idx_d : '0;
    frame_done_d = state_d == S_SHOW && cnt_d == CW'(DIGIT_CYCLES - 1) && idx_d == IW'(NUM_DIGITS - 1);
  end

  // scan FSM, data registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_OFF;
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pending_q    <= 1'b0;
      blz_q        <= 1'b0;
      seven_q      <= '0;
      an_q         <= '0;
      frame_done_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pending_q    <= pending_d;
      blz_q        <= blz_d;
      seven_q      <= seven_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
      ready_q      <= !pending_d;
    end
  end

  assign bus.seven      = seven_q;
  assign bus.digit_an   = an_q;
  assign bus.frame_done = frame_done_q;
  assign bus.load_ready = ready_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed plus random scan/load checks against a frame-position reference model
module tb_seven_seg_scan_ctrl;
  localparam int N = 4;
  localparam int D = 10;
  localparam int B = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();
  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .DIGIT_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  // model: on/off, position in the frame, shown and staged words
  bit          m_on = 0;
  int          m_p = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  bit          m_pending = 0;
  bit          m_blz = 0;
  bit          m_acc = 0;

  function automatic bit shown();
    return m_on && (m_p % D) >= B;
  endfunction

  function automatic logic [7:1] exp_seven();
    int slot;
    logic [3:0] nib;
    slot = (m_p / D) % N;
    if (!shown()) return '0;
    nib = m_disp[4*slot +: 4];
    if (slot > 0 && m_blz && (m_disp >> (4 * slot)) == 16'h0) return '0;
    return nib <= 4'd9 ? seg_tab[nib] : 7'b0;
  endfunction

  function automatic logic [N-1:0] exp_an();
    return shown() ? N'(1 << ((m_p / D) % N)) : '0;
  endfunction

  function automatic bit exp_fd();
    return m_on && (m_p % D) == D - 1 && (m_p / D) % N == N - 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare();
    chk("seven", 32'(bus.seven), 32'(exp_seven()));
    chk("digit_an", 32'(bus.digit_an), 32'(exp_an()));
    chk("frame_done", 32'(bus.frame_done), 32'(exp_fd()));
    chk("load_ready", 32'(bus.load_ready), 32'(!m_pending));
  endtask

  task automatic model_edge();
    bit last;
    bit xfer;
    last = exp_fd();
    xfer = bus.load_valid && !m_pending;
    m_acc = xfer;
    if (m_pending && (!m_on || last)) begin
      m_disp = m_pend;
      m_pending = 0;
    end else if (xfer && !m_on) begin
      m_disp = bus.load_data;
    end else if (xfer) begin
      m_pend = bus.load_data;
      m_pending = 1;
    end
    if (!bus.disp_en) begin
      m_on = 0;
      m_p = 0;
    end else if (!m_on) begin
      m_on = 1;
      m_p = 0;
    end else begin
      m_p = (m_p + 1) % (N * D);
    end
    if (m_on && (m_p % D) == B) m_blz = bus.blank_lz;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic goto(input int p);
    int n;
    n = 0;
    while (!(m_on && m_p == p) && n < 500) begin
      step();
      n++;
    end
    chk("goto_reached", 32'(n < 500), 32'd1);
  endtask

  task automatic load(input logic [15:0] d);
    bus.load_valid = 1'b1;
    bus.load_data = d;
    step();
    bus.load_valid = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    m_on = 0;
    m_p = 0;
    m_disp = '0;
    m_pend = '0;
    m_pending = 0;
    m_blz = 0;
    compare();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_data();
    logic [15:0] d;
    int r;
    for (int i = 0; i < N; i++) begin
      r = $urandom_range(0, 15);
      d[4*i +: 4] = r < 8 ? 4'd0 : r < 15 ? 4'($urandom_range(1, 9)) : 4'($urandom_range(10, 15));
    end
    return d;
  endfunction

  initial begin
    int fd;
    bus.disp_en = 1'b0;
    bus.blank_lz = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data = '0;
    repeat (2) step();
    rst_n = 1'b1;
    // direct load while off, then scan 1234
    load(16'h1234);
    bus.disp_en = 1'b1;
    step();
    chk("first_blank_an", 32'(bus.digit_an), 32'd0);
    step();
    step();
    chk("d0_an", 32'(bus.digit_an), 32'b0001);
    chk("d0_seven", 32'(bus.seven), 32'b1100110);
    fd = 0;
    repeat (80) begin
      step();
      fd += int'(bus.frame_done);
    end
    chk("frame_done_count", 32'(fd), 32'd2);
    // staged load commits only at the frame boundary
    goto(17);
    load(16'h5678);
    chk("ready_low_pending", 32'(bus.load_ready), 32'd0);
    goto(N * D - 1);
    chk("fd_pulse", 32'(bus.frame_done), 32'd1);
    chk("old_frame_an", 32'(bus.digit_an), 32'b1000);
    chk("old_frame_seven", 32'(bus.seven), 32'b0000110);
    chk("ready_still_low", 32'(bus.load_ready), 32'd0);
    step();
    chk("ready_back", 32'(bus.load_ready), 32'd1);
    goto(2);
    chk("new_frame_seven", 32'(bus.seven), 32'b1111111);
    // leading-zero blanking
    bus.blank_lz = 1'b1;
    load(16'h0070);
    goto(N * D - 1);
    goto(2);
    chk("lz_d0", 32'(bus.seven), 32'b0111111);
    goto(12);
    chk("lz_d1", 32'(bus.seven), 32'b0000111);
    goto(22);
    chk("lz_d2_an", 32'(bus.digit_an), 32'b0100);
    chk("lz_d2_seven", 32'(bus.seven), 32'd0);
    goto(32);
    chk("lz_d3_seven", 32'(bus.seven), 32'd0);
    bus.blank_lz = 1'b0;
    goto(22);
    chk("nolz_d2_seven", 32'(bus.seven), 32'b0111111);
    goto(32);
    chk("nolz_d3_seven", 32'(bus.seven), 32'b0111111);
    // disable mid-frame, direct load, restart at digit 0 with gap
    goto(15);
    bus.disp_en = 1'b0;
    step();
    chk("off_an", 32'(bus.digit_an), 32'd0);
    chk("off_seven", 32'(bus.seven), 32'd0);
    load(16'hA009);
    chk("off_direct_ready", 32'(bus.load_ready), 32'd1);
    bus.disp_en = 1'b1;
    step();
    chk("restart_blank", 32'(bus.digit_an), 32'd0);
    goto(2);
    chk("restart_d0_an", 32'(bus.digit_an), 32'b0001);
    chk("restart_d0_seven", 32'(bus.seven), 32'b1101111);
    goto(32);
    chk("invalid_an", 32'(bus.digit_an), 32'b1000);
    chk("invalid_seven", 32'(bus.seven), 32'd0);
    // pending load commits on the first OFF cycle
    goto(5);
    load(16'h0001);
    bus.disp_en = 1'b0;
    step();
    chk("off_pending_ready", 32'(bus.load_ready), 32'd0);
    step();
    chk("off_commit_ready", 32'(bus.load_ready), 32'd1);
    bus.disp_en = 1'b1;
    // async reset mid-SHOW drops a staged load
    goto(15);
    load(16'h9999);
    chk("pre_reset_ready", 32'(bus.load_ready), 32'd0);
    async_reset();
    goto(2);
    chk("post_reset_d0", 32'(bus.seven), 32'b0111111);
    goto(12);
    chk("post_reset_d1", 32'(bus.seven), 32'b0111111);
    // random traffic
    m_acc = 0;
    repeat (3000) begin
      if (!bus.load_valid || m_acc) begin
        bus.load_valid = $urandom_range(0, 9) == 0;
        bus.load_data = rand_data();
      end
      if (bus.disp_en ? $urandom_range(0, 199) == 0 : $urandom_range(0, 9) == 0) bus.disp_en = !bus.disp_en;
      if ($urandom_range(0, 49) == 0) bus.blank_lz = 1'($urandom_range(0, 1));
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
